// File: rtl/icache_controller.sv
// Instruction-cache sequencer: tag compare against an external 1-cycle array,
// block refill from memory one word per beat, and fence.i bulk invalidate.
module icache_controller #(
  parameter int offset_width = 2,
  parameter int line_width   = 6,
  localparam int tag_width   = 30 - offset_width - line_width,
  localparam int block_size  = 1 << offset_width
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [31:0]              req_addr,
  output logic                     resp_valid,
  output logic [31:0]              resp_instr,
  input  logic                     invalidate,
  output logic [31:0]              arr_address,
  input  logic [31:0]              arr_instruction,
  input  logic [tag_width-1:0]     arr_tag,
  input  logic                     arr_tag_valid,
  output logic                     arr_write_in,
  output logic [line_width-1:0]    arr_write_line_index,
  output logic [32*block_size-1:0] arr_write_block,
  output logic [tag_width-1:0]     arr_write_tag,
  output logic                     arr_invalidate_all,
  output logic                     mem_req_valid,
  input  logic                     mem_req_ready,
  output logic [31:0]              mem_req_addr,
  input  logic                     mem_resp_valid,
  input  logic [31:0]              mem_resp_data
);

  typedef enum logic [2:0] {IDLE, COMPARE, MEM_REQ, MEM_RESP, FILL} state_t;

  state_t                  state_q, state_d;
  logic [offset_width-1:0] beat_q, beat_d;
  logic                    inv_pending_q, inv_pending_d;
  logic [31:0]             addr_q, addr_d;
  logic [31:0]             buffer_q [block_size];

  logic [tag_width-1:0]    addr_tag;
  logic [offset_width-1:0] addr_word;
  logic                    buf_we;

  assign addr_tag             = addr_q[31:line_width+offset_width+2];
  assign addr_word            = addr_q[offset_width+1:2];
  assign arr_write_line_index = addr_q[line_width+offset_width+1:offset_width+2];
  assign arr_write_tag        = addr_tag;
  assign mem_req_addr         = {addr_q[31:offset_width+2], {(offset_width+2){1'b0}}};
  assign buf_we               = (state_q == MEM_RESP) && mem_resp_valid;

  // Refill buffer: one register per word, written at the current beat.
  for (genvar gi = 0; gi < block_size; gi++) begin : g_buf
    always_ff @(posedge clock) begin
      if (buf_we && (beat_q == offset_width'(gi))) begin
        buffer_q[gi] <= mem_resp_data;
      end
    end
    assign arr_write_block[32*gi +: 32] = buffer_q[gi];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      beat_q        <= '0;
      inv_pending_q <= 1'b0;
      addr_q        <= '0;
    end else begin
      state_q       <= state_d;
      beat_q        <= beat_d;
      inv_pending_q <= inv_pending_d;
      addr_q        <= addr_d;
    end
  end

  always_comb begin
    state_d            = state_q;
    beat_d             = beat_q;
    inv_pending_d      = inv_pending_q;
    addr_d             = addr_q;
    resp_valid         = 1'b0;
    resp_instr         = '0;
    arr_write_in       = 1'b0;
    arr_invalidate_all = 1'b0;
    mem_req_valid      = 1'b0;
    req_ready          = (state_q == IDLE) && !inv_pending_q && !invalidate;
    arr_address        = (state_q == IDLE) ? req_addr : addr_q;

    // A fence seen while busy is deferred until after any pending FILL write.
    if (state_q != IDLE && invalidate) begin
      inv_pending_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (inv_pending_q || invalidate) begin
          arr_invalidate_all = 1'b1;
          inv_pending_d      = 1'b0;
        end else if (req_valid) begin
          addr_d  = req_addr;
          state_d = COMPARE;
        end
      end
      COMPARE: begin
        if (arr_tag_valid && (arr_tag == addr_tag)) begin
          resp_valid = 1'b1;
          resp_instr = arr_instruction;
          state_d    = IDLE;
        end else begin
          beat_d  = '0;
          state_d = MEM_REQ;
        end
      end
      MEM_REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) begin
          state_d = MEM_RESP;
        end
      end
      MEM_RESP: begin
        if (mem_resp_valid) begin
          beat_d = beat_q + 1'b1;
          if (beat_q == offset_width'(block_size - 1)) begin
            state_d = FILL;
          end
        end
      end
      FILL: begin
        arr_write_in = 1'b1;
        resp_valid   = 1'b1;
        resp_instr   = buffer_q[addr_word];
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_icache_controller.sv
// Directed bench for icache_controller with a behavioural tag/data array and
// a hand-driven memory port.
module tb_icache_controller;

  logic          clock, reset, req_valid, invalidate;
  logic [31:0]   req_addr, arr_instruction, mem_resp_data;
  logic [21:0]   arr_tag;
  logic          arr_tag_valid, mem_req_ready, mem_resp_valid;
  logic          req_ready, resp_valid, arr_write_in, arr_invalidate_all, mem_req_valid;
  logic [31:0]   resp_instr, arr_address, mem_req_addr;
  logic [5:0]    arr_write_line_index;
  logic [127:0]  arr_write_block;
  logic [21:0]   arr_write_tag;

  int tests_run = 0;
  int tests_failed = 0;

  logic          rdy, mrv, wr, rv, model_clr;
  logic [31:0]   maddr, ri;
  logic [5:0]    idx;
  logic [21:0]   tg;
  logic [127:0]  blk;

  icache_controller dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .resp_valid(resp_valid), .resp_instr(resp_instr),
    .invalidate(invalidate), .arr_address(arr_address),
    .arr_instruction(arr_instruction), .arr_tag(arr_tag), .arr_tag_valid(arr_tag_valid),
    .arr_write_in(arr_write_in), .arr_write_line_index(arr_write_line_index),
    .arr_write_block(arr_write_block), .arr_write_tag(arr_write_tag),
    .arr_invalidate_all(arr_invalidate_all), .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural array: registered read, block write, bulk valid clear.
  logic [21:0] m_tag   [64];
  logic        m_valid [64];
  logic [31:0] m_data  [64][4];

  always @(posedge clock) begin
    arr_instruction <= m_data[arr_address[9:4]][arr_address[3:2]];
    arr_tag         <= m_tag[arr_address[9:4]];
    arr_tag_valid   <= m_valid[arr_address[9:4]];
    if (model_clr || arr_invalidate_all) begin
      for (int i = 0; i < 64; i++) m_valid[i] <= 1'b0;
    end else if (arr_write_in) begin
      m_tag[arr_write_line_index]   <= arr_write_tag;
      m_valid[arr_write_line_index] <= 1'b1;
      for (int j = 0; j < 4; j++) m_data[arr_write_line_index][j] <= arr_write_block[32*j +: 32];
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Present a request for one cycle; returns with the DUT in the cycle after acceptance.
  task automatic issue(input logic [31:0] a, output logic o_rdy);
    req_valid = 1'b1;
    req_addr  = a;
    #1 o_rdy = req_ready;
    step();
    req_valid = 1'b0;
    #1;
  endtask

  // From a COMPARE-miss cycle: grant the request, return 4 beats d0..d0+3, sample FILL.
  task automatic refill(input logic [31:0] d0, output logic o_mrv, output logic [31:0] o_maddr,
                        output logic o_wr, output logic [5:0] o_idx, output logic [21:0] o_tag,
                        output logic [127:0] o_blk, output logic o_rv, output logic [31:0] o_ri);
    step();
    mem_req_ready = 1'b1;
    #1;
    o_mrv   = mem_req_valid;
    o_maddr = mem_req_addr;
    step();
    mem_req_ready = 1'b0;
    for (int j = 0; j < 4; j++) begin
      mem_resp_valid = 1'b1;
      mem_resp_data  = d0 + j;
      step();
    end
    mem_resp_valid = 1'b0;
    #1;
    o_wr = arr_write_in; o_idx = arr_write_line_index; o_tag = arr_write_tag;
    o_blk = arr_write_block; o_rv = resp_valid; o_ri = resp_instr;
    $display("[TB] refill addr=%h line=%h tag=%h resp=%h", o_maddr, o_idx, o_tag, o_ri);
    step();
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; model_clr = 1'b1;
    step(); step();
    reset = 1'b0; model_clr = 1'b0;
    #1;
    tests_run++; if (req_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
    tests_run++; if (resp_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_resp_valid: got %b want 0", resp_valid); end
    tests_run++; if (resp_instr !== 32'h0) begin tests_failed++; $display("FAIL reset_resp_instr: got %h want 0", resp_instr); end
    tests_run++; if ({mem_req_valid, arr_write_in, arr_invalidate_all} !== 3'b000) begin tests_failed++; $display("FAIL reset_strobes: got %b want 000", {mem_req_valid, arr_write_in, arr_invalidate_all}); end
    $display("[TB] reset done");
  endtask

  task automatic test_miss_fill();
    issue(32'h0000_0100, rdy);
    tests_run++; if (rdy !== 1'b1) begin tests_failed++; $display("FAIL miss_accept: got %b want 1", rdy); end
    tests_run++; if (resp_valid !== 1'b0) begin tests_failed++; $display("FAIL miss_compare: got resp_valid %b want 0", resp_valid); end
    refill(32'hA0, mrv, maddr, wr, idx, tg, blk, rv, ri);
    tests_run++; if (mrv !== 1'b1 || maddr !== 32'h0000_0100) begin tests_failed++; $display("FAIL miss_memreq: got v=%b a=%h want 1/00000100", mrv, maddr); end
    tests_run++; if (wr !== 1'b1 || idx !== 6'h10 || tg !== 22'h0) begin tests_failed++; $display("FAIL miss_write: got w=%b i=%h t=%h want 1/10/0", wr, idx, tg); end
    tests_run++; if (blk !== 128'h000000A3_000000A2_000000A1_000000A0) begin tests_failed++; $display("FAIL miss_block: got %h", blk); end
    tests_run++; if (rv !== 1'b1 || ri !== 32'hA0) begin tests_failed++; $display("FAIL miss_resp: got v=%b d=%h want 1/a0", rv, ri); end
    tests_run++; if (resp_valid !== 1'b0 || arr_write_in !== 1'b0) begin tests_failed++; $display("FAIL miss_after: got rv=%b wr=%b want 0/0", resp_valid, arr_write_in); end
  endtask

  task automatic test_hit();
    issue(32'h0000_0108, rdy);
    tests_run++; if (resp_valid !== 1'b1 || resp_instr !== 32'hA2) begin tests_failed++; $display("FAIL hit_resp: got v=%b d=%h want 1/a2", resp_valid, resp_instr); end
    tests_run++; if (mem_req_valid !== 1'b0) begin tests_failed++; $display("FAIL hit_nomem: got %b want 0", mem_req_valid); end
    step();
    tests_run++; if (resp_valid !== 1'b0 || req_ready !== 1'b1 || mem_req_valid !== 1'b0) begin tests_failed++; $display("FAIL hit_pulse: got rv=%b rdy=%b mrv=%b want 0/1/0", resp_valid, req_ready, mem_req_valid); end
    $display("[TB] hit addr=00000108 resp=a2");
  endtask

  task automatic test_eviction();
    issue(32'h0001_0100, rdy);
    tests_run++; if (resp_valid !== 1'b0) begin tests_failed++; $display("FAIL evict_miss1: got %b want 0", resp_valid); end
    refill(32'hB0, mrv, maddr, wr, idx, tg, blk, rv, ri);
    tests_run++; if (maddr !== 32'h0001_0100 || idx !== 6'h10 || tg !== 22'h40) begin tests_failed++; $display("FAIL evict_fill: got a=%h i=%h t=%h want 00010100/10/40", maddr, idx, tg); end
    tests_run++; if (ri !== 32'hB0) begin tests_failed++; $display("FAIL evict_resp: got %h want b0", ri); end
    issue(32'h0000_0100, rdy);
    tests_run++; if (resp_valid !== 1'b0) begin tests_failed++; $display("FAIL evict_miss2: got %b want 0", resp_valid); end
    refill(32'hC0, mrv, maddr, wr, idx, tg, blk, rv, ri);
    tests_run++; if (tg !== 22'h0 || ri !== 32'hC0) begin tests_failed++; $display("FAIL evict_refill: got t=%h d=%h want 0/c0", tg, ri); end
  endtask

  task automatic test_stall();
    int bad = 0;
    issue(32'h0000_02C4, rdy);
    tests_run++; if (resp_valid !== 1'b0) begin tests_failed++; $display("FAIL stall_miss: got %b want 0", resp_valid); end
    step();
    for (int c = 0; c < 5; c++) begin
      req_valid = 1'b1; req_addr = 32'h0000_0500;
      #1;
      if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h0000_02C0 || req_ready !== 1'b0 || arr_address !== 32'h0000_02C4) bad++;
      step();
    end
    req_valid = 1'b0;
    tests_run++; if (bad !== 0) begin tests_failed++; $display("FAIL stall_hold: got %0d bad cycles want 0", bad); end
    mem_req_ready = 1'b1;
    #1;
    tests_run++; if (mem_req_valid !== 1'b1) begin tests_failed++; $display("FAIL stall_release: got %b want 1", mem_req_valid); end
    step();
    mem_req_ready = 1'b0;
    for (int j = 0; j < 4; j++) begin
      mem_resp_valid = 1'b1; mem_resp_data = 32'hD0 + j;
      step();
    end
    mem_resp_valid = 1'b0;
    #1;
    tests_run++; if (resp_valid !== 1'b1 || resp_instr !== 32'hD1 || arr_write_line_index !== 6'h2C) begin tests_failed++; $display("FAIL stall_fill: got v=%b d=%h i=%h want 1/d1/2c", resp_valid, resp_instr, arr_write_line_index); end
    $display("[TB] stalled refill addr=000002c4 resp=%h", resp_instr);
    step(); #1;
  endtask

  task automatic test_invalidate();
    issue(32'h0000_0300, rdy);
    step();
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    for (int j = 0; j < 4; j++) begin
      mem_resp_valid = 1'b1; mem_resp_data = 32'hE0 + j; invalidate = (j == 2);
      step();
    end
    mem_resp_valid = 1'b0; invalidate = 1'b0;
    #1;
    tests_run++; if (arr_write_in !== 1'b1 || arr_invalidate_all !== 1'b0 || resp_valid !== 1'b1 || resp_instr !== 32'hE0) begin tests_failed++; $display("FAIL inv_fill: got wr=%b inv=%b v=%b d=%h want 1/0/1/e0", arr_write_in, arr_invalidate_all, resp_valid, resp_instr); end
    step();
    tests_run++; if (arr_invalidate_all !== 1'b1 || arr_write_in !== 1'b0 || req_ready !== 1'b0) begin tests_failed++; $display("FAIL inv_apply: got inv=%b wr=%b rdy=%b want 1/0/0", arr_invalidate_all, arr_write_in, req_ready); end
    step();
    tests_run++; if (arr_invalidate_all !== 1'b0 || req_ready !== 1'b1) begin tests_failed++; $display("FAIL inv_once: got inv=%b rdy=%b want 0/1", arr_invalidate_all, req_ready); end
    issue(32'h0000_0300, rdy);
    tests_run++; if (resp_valid !== 1'b0) begin tests_failed++; $display("FAIL inv_miss300: got %b want 0", resp_valid); end
    refill(32'hE8, mrv, maddr, wr, idx, tg, blk, rv, ri);
    tests_run++; if (ri !== 32'hE8) begin tests_failed++; $display("FAIL inv_refill300: got %h want e8", ri); end
    issue(32'h0000_0108, rdy);
    tests_run++; if (resp_valid !== 1'b0) begin tests_failed++; $display("FAIL inv_miss108: got %b want 0", resp_valid); end
    refill(32'h10, mrv, maddr, wr, idx, tg, blk, rv, ri);
    tests_run++; if (ri !== 32'h12) begin tests_failed++; $display("FAIL inv_refill108: got %h want 12", ri); end
  endtask

  task automatic test_idle_invalidate();
    invalidate = 1'b1; req_valid = 1'b1; req_addr = 32'h0000_0300;
    #1;
    tests_run++; if (req_ready !== 1'b0 || arr_invalidate_all !== 1'b1) begin tests_failed++; $display("FAIL idleinv_now: got rdy=%b inv=%b want 0/1", req_ready, arr_invalidate_all); end
    step();
    invalidate = 1'b0; req_valid = 1'b0;
    #1;
    tests_run++; if (req_ready !== 1'b1 || resp_valid !== 1'b0 || mem_req_valid !== 1'b0) begin tests_failed++; $display("FAIL idleinv_noaccept: got rdy=%b v=%b mrv=%b want 1/0/0", req_ready, resp_valid, mem_req_valid); end
    issue(32'h0000_0300, rdy);
    tests_run++; if (resp_valid !== 1'b0) begin tests_failed++; $display("FAIL idleinv_miss: got %b want 0", resp_valid); end
    refill(32'h21, mrv, maddr, wr, idx, tg, blk, rv, ri);
    tests_run++; if (ri !== 32'h21 || idx !== 6'h30) begin tests_failed++; $display("FAIL idleinv_refill: got d=%h i=%h want 21/30", ri, idx); end
  endtask

  task automatic test_reset_midrefill();
    issue(32'h0000_0400, rdy);
    step();
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    mem_resp_valid = 1'b1; mem_resp_data = 32'hF0;
    step();
    mem_resp_data = 32'hF1; reset = 1'b1;
    step();
    reset = 1'b0; mem_resp_data = 32'h99;
    #1;
    tests_run++; if ({resp_valid, mem_req_valid, arr_write_in, arr_invalidate_all} !== 4'b0000 || resp_instr !== 32'h0) begin tests_failed++; $display("FAIL rst_outputs: got %b d=%h want 0000/0", {resp_valid, mem_req_valid, arr_write_in, arr_invalidate_all}, resp_instr); end
    tests_run++; if (req_ready !== 1'b1) begin tests_failed++; $display("FAIL rst_idle: got %b want 1", req_ready); end
    step();
    tests_run++; if (arr_write_in !== 1'b0 || resp_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_stray: got wr=%b v=%b want 0/0", arr_write_in, resp_valid); end
    mem_resp_valid = 1'b0;
    issue(32'h0000_040C, rdy);
    tests_run++; if (rdy !== 1'b1 || resp_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_newmiss: got rdy=%b v=%b want 1/0", rdy, resp_valid); end
    refill(32'hF0, mrv, maddr, wr, idx, tg, blk, rv, ri);
    tests_run++; if (maddr !== 32'h0000_0400 || idx !== 6'h00 || tg !== 22'h1 || ri !== 32'hF3) begin tests_failed++; $display("FAIL rst_refill: got a=%h i=%h t=%h d=%h want 00000400/00/1/f3", maddr, idx, tg, ri); end
    tests_run++; if (blk !== 128'h000000F3_000000F2_000000F1_000000F0) begin tests_failed++; $display("FAIL rst_block: got %h", blk); end
    issue(32'h0000_0404, rdy);
    tests_run++; if (resp_valid !== 1'b1 || resp_instr !== 32'hF1) begin tests_failed++; $display("FAIL rst_hit: got v=%b d=%h want 1/f1", resp_valid, resp_instr); end
    step();
  endtask

  initial begin
    reset = 1'b1; model_clr = 1'b1; req_valid = 1'b0; req_addr = '0; invalidate = 1'b0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;
    test_reset();
    test_miss_fill();
    test_hit();
    test_eviction();
    test_stall();
    test_invalidate();
    test_idle_invalidate();
    test_reset_midrefill();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
